pc_stack_seq: RTL

//  Parametrised program counter for the capstone core, successor to the 8-bit inc/jump PC.

---
 rtl/pc_pkg.sv | 32 +++
 rtl/pc_ret_stack.sv | 49 ++++
 rtl/pc_stack_seq.sv | 93 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program counter: operation encoding, default widths and
// the per-cycle command priority decode.
package pc_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_OFF_W       = 8;
  localparam int DEF_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_JMP,
    PC_BR,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // Exactly one operation per cycle: stall > ret > call > jmp > br > inc > hold.
  // Reset is handled by the registers themselves and sits above all of these.
  function automatic pc_op_e pc_decode(input logic stall, input logic ret,
                                       input logic call, input logic jmp,
                                       input logic br, input logic inc);
    if (stall)     return PC_HOLD;
    else if (ret)  return PC_RET;
    else if (call) return PC_CALL;
    else if (jmp)  return PC_JMP;
    else if (br)   return PC_BR;
    else if (inc)  return PC_INC;
    else           return PC_HOLD;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: push/pop with a depth counter, full/empty decodes and
// the current top entry. Push when full and pop when empty leave it untouched.
module pc_ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] depth;
  logic [CNT_W-1:0] depth_m1;

  assign depth_m1 = depth - CNT_W'(1);
  assign empty    = (depth == '0);
  assign full     = (depth == CNT_W'(DEPTH));
  assign top      = empty ? '0 : mem[depth_m1[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + CNT_W'(1);
    end else if (pop && !empty) begin
      depth <= depth_m1;
    end
  end

  // NOTE: the entry array is deliberately not reset; the depth counter alone
  // defines which entries are valid, so clearing storage would only cost logic.
  always_ff @(posedge clk) begin
    if (push && !full && !rst) begin
      mem[depth[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack_seq.sv
// Program counter with inc, jump, relative branch and call/return through an
// internal return stack. Define PC_STACK_ERR_EN to enable the sticky stack_err flag.
module pc_stack_seq
  import pc_pkg::*;
#(
  parameter int                 ADDR_W      = DEF_ADDR_W,
  parameter int                 OFF_W       = DEF_OFF_W,
  parameter int                 STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              inc,
  input  logic              jmp,
  input  logic              br,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [OFF_W-1:0]  offset_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  pc_op_e            op;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pc_next;
  logic              push;
  logic              pop;

  assign op      = pc_decode(stall, ret, call, jmp, br, inc);
  assign pc_inc  = pc + ADDR_W'(1);
  assign off_ext = ADDR_W'($signed(offset_in));
  assign push    = (op == PC_CALL);
  assign pop     = (op == PC_RET);

  pc_ret_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .empty     (stack_empty),
    .full      (stack_full)
  );

  // NOTE: pc_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next = pc;
    unique case (op)
      PC_INC:  pc_next = pc_inc;
      PC_JMP:  pc_next = addr_in;
      PC_BR:   pc_next = pc + off_ext;
      PC_CALL: pc_next = addr_in;
      PC_RET:  pc_next = stack_empty ? pc_inc : stack_top;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_ADDR;
    else     pc <= pc_next;
  end

  assign addr_out = pc;

`ifdef PC_STACK_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((op == PC_CALL && stack_full) || (op == PC_RET && stack_empty)) begin
      err_q <= 1'b1;
    end
  end

  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

endmodule
